// File: rtl/digit_scan_ctrl.sv
// Scan controller for a multiplexed 8-digit display: prescaled digit stepping,
// frame-latched active-digit count, and an 8 x 4-bit digit register file.
module digit_scan_ctrl #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] num_digits,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [2:0] sel,
  output logic [3:0] digit,
  output logic       tick,
  output logic       frame_done,
  output logic       blank
);

  localparam logic [15:0] CNT_MAX = 16'(PRESCALE - 32'd1);

  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [2:0]  sel_r;
  logic [2:0]  sel_nxt_s;
  logic [2:0]  last_q_r;
  logic [2:0]  last_nxt_s;
  logic        tick_r;
  logic        tick_nxt_s;
  logic        frame_done_r;
  logic        frame_done_nxt_s;
  logic        blank_r;
  logic [3:0]  mem_r [8];

  // Prescaler and scan stepping; last_q only reloads on the wrap so a frame is never cut short.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    sel_nxt_s        = sel_r;
    last_nxt_s       = last_q_r;
    tick_nxt_s       = 1'b0;
    frame_done_nxt_s = 1'b0;
    if (en) begin
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s  = 16'd0;
        tick_nxt_s = 1'b1;
        if (sel_r == last_q_r) begin
          sel_nxt_s        = 3'd0;
          frame_done_nxt_s = 1'b1;
          last_nxt_s       = num_digits;
        end else begin
          sel_nxt_s = sel_r + 3'd1;
        end
      end else begin
        cnt_nxt_s = cnt_r + 16'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Scan state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r        <= 16'd0;
      sel_r        <= 3'd0;
      last_q_r     <= 3'd7;
      tick_r       <= 1'b0;
      frame_done_r <= 1'b0;
      blank_r      <= 1'b1;
    end else begin
      cnt_r        <= cnt_nxt_s;
      sel_r        <= sel_nxt_s;
      last_q_r     <= last_nxt_s;
      tick_r       <= tick_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      blank_r      <= ~en;
    end
  end

  // Digit register file; writes are independent of the scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_r[i] <= 4'd0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign sel        = sel_r;
  assign digit      = mem_r[sel_r];
  assign tick       = tick_r;
  assign frame_done = frame_done_r;
  assign blank      = blank_r;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: one instance with PRESCALE=4, one with PRESCALE=1.
module tb_digit_scan_ctrl;

  logic       clk;
  logic       rst_n, en;
  logic [2:0] num_digits;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [2:0] sel;
  logic [3:0] digit;
  logic       tick, frame_done, blank;

  logic       rst1_n, en1;
  logic [2:0] num_digits1;
  logic [2:0] sel1;
  logic [3:0] digit1;
  logic       tick1, frame_done1, blank1;

  int npass  = 0;
  int ntotal = 0;

  digit_scan_ctrl #(.PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .num_digits(num_digits),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .digit(digit), .tick(tick), .frame_done(frame_done), .blank(blank)
  );

  digit_scan_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .num_digits(num_digits1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel1), .digit(digit1), .tick(tick1), .frame_done(frame_done1), .blank(blank1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Loaded contents: mem[i] = i+5, except mem[5] overwritten with 4'hA.
  function automatic int mem_exp(int s);
    return (s == 5) ? 10 : s + 5;
  endfunction

  initial begin
    int seq_a[5] = '{7, 0, 1, 2, 3};
    int seq_b[9] = '{4, 5, 6, 7, 0, 1, 2, 0, 1};
    int es;

    rst_n = 1'b0; en = 1'b0; num_digits = 3'd7;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    rst1_n = 1'b0; en1 = 1'b0; num_digits1 = 3'd0;
    tk();
    tk();
    chk("rst_sel", int'(sel), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst1_blank", int'(blank1), 1);

    // 1: full 8-digit frame, one step every 4 cycles
    rst_n = 1'b1; rst1_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      repeat (3) begin
        tk();
        chk("t1_notick", int'(tick), 0);
      end
      tk();
      chk("t1_sel", int'(sel), k % 8);
      chk("t1_tick", int'(tick), 1);
      chk("t1_fd", int'(frame_done), int'(k == 8));
    end
    chk("t1_blank", int'(blank), 0);

    // 3: load mem[i]=i+5 while scanning (sel ends at 2, cnt 0)
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 5);
      tk();
    end
    wr_en = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tk();
      es = 2 + j / 4;
      chk("t3_sel", int'(sel), es);
      chk("t3_digit", int'(digit), es + 5);
    end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hA;
    tk();
    wr_en = 1'b0;
    chk("t3_wr_sel", int'(sel), 5);
    chk("t3_wr_digit", int'(digit), 10);

    // 4: drop en at cnt=2, sel=5 for 10 cycles
    tk();
    chk("t4_pre_blank", int'(blank), 0);
    en = 1'b0;
    repeat (10) begin
      tk();
      chk("t4_sel", int'(sel), 5);
      chk("t4_tick", int'(tick), 0);
      chk("t4_blank", int'(blank), 1);
    end
    en = 1'b1;
    tk();
    chk("t4_re1_sel", int'(sel), 5);
    chk("t4_re1_tick", int'(tick), 0);
    chk("t4_re1_blank", int'(blank), 0);
    tk();
    chk("t4_re2_sel", int'(sel), 6);
    chk("t4_re2_tick", int'(tick), 1);
    chk("t4_re2_digit", int'(digit), 11);

    // 2: num_digits 7->2 at sel=3 takes effect only after the wrap
    for (int k = 0; k < 5; k++) begin
      repeat (4) tk();
      chk("t2a_sel", int'(sel), seq_a[k]);
      chk("t2a_fd", int'(frame_done), int'(seq_a[k] == 0));
      chk("t2a_digit", int'(digit), mem_exp(seq_a[k]));
    end
    num_digits = 3'd2;
    for (int k = 0; k < 9; k++) begin
      repeat (4) tk();
      chk("t2b_sel", int'(sel), seq_b[k]);
      chk("t2b_tick", int'(tick), 1);
      chk("t2b_fd", int'(frame_done), int'(seq_b[k] == 0));
    end

    // 6: reset mid-frame clears mem and restores last_q=7
    chk("t6_pre_digit", int'(digit), 6);
    rst_n = 1'b0;
    tk();
    chk("t6_sel", int'(sel), 0);
    chk("t6_digit", int'(digit), 0);
    chk("t6_blank", int'(blank), 1);
    chk("t6_tick", int'(tick), 0);
    chk("t6_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      repeat (4) tk();
      chk("t6_scan_sel", int'(sel), k % 8);
      chk("t6_scan_digit", int'(digit), 0);
      chk("t6_scan_fd", int'(frame_done), int'(k == 8));
    end
    chk("t6_blank_after", int'(blank), 0);

    // 5: PRESCALE=1, num_digits=0 (first frame still uses reset last_q=7)
    en1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tk();
      chk("t5_sel", int'(sel1), k % 8);
      chk("t5_tick", int'(tick1), 1);
      chk("t5_fd", int'(frame_done1), int'(k == 8));
    end
    repeat (4) begin
      tk();
      chk("t5_hold_sel", int'(sel1), 0);
      chk("t5_hold_tick", int'(tick1), 1);
      chk("t5_hold_fd", int'(frame_done1), 1);
    end
    en1 = 1'b0;
    tk();
    chk("t5_off_tick", int'(tick1), 0);
    chk("t5_off_fd", int'(frame_done1), 0);
    chk("t5_off_sel", int'(sel1), 0);
    chk("t5_off_blank", int'(blank1), 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
